if_fetch_unit: RTL

Instruction-fetch stage of the five-stage LoongArch pipeline. It generates the next PC, drives the synchronous instruction SRAM, and holds the fetched {pc, inst} pair in the IF pipeline register. It delivers that pair to the decode stage over a valid/ready handshake. It also consumes the decode-stage redirect bus `br_bus` and squashes the wrong-path instruction on a taken branch.

---
 rtl/if_fetch_unit.sv | 68 ++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: next-PC generation, instruction SRAM drive, IF register with stall buffer and branch squash
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic [32:0] br_bus,
  input  logic        ID_Unit_Ready,
  output logic        IF_Valid,
  output logic [63:0] IF_to_ID_Bus
);

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        to_fs_valid;
  logic        fs_allowin;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic [31:0] inst_buf;
  logic        buf_valid;

  assign br_taken    = br_bus[32];
  assign br_target   = br_bus[31:0];
  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br_taken ? br_target : seq_pc;
  assign to_fs_valid = ~reset;
  // A taken branch frees the IF slot even mid-stall: the held entry is wrong-path.
  assign fs_allowin  = ~fs_valid | ID_Unit_Ready | br_taken;

  assign inst_sram_en    = to_fs_valid & fs_allowin;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid  <= 1'b0;
      fs_pc     <= RESET_PC - 32'd4;
      buf_valid <= 1'b0;
      inst_buf  <= 32'b0;
    end else begin
      if (fs_allowin) begin
        fs_valid <= to_fs_valid;
        fs_pc    <= nextpc;
      end
      // SRAM output only lasts one cycle, so keep a copy while decode stalls.
      if (br_taken || (fs_valid && ID_Unit_Ready)) begin
        buf_valid <= 1'b0;
      end else if (fs_valid && !ID_Unit_Ready && !buf_valid) begin
        inst_buf  <= inst_sram_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

  assign fs_inst      = buf_valid ? inst_buf : inst_sram_rdata;
  assign IF_to_ID_Bus = {fs_pc, fs_inst};
  assign IF_Valid     = fs_valid & ~br_taken;

endmodule
